// File: rtl/pong_pkg.sv
// Shared definitions for the pong display pipeline: screen size, field widths,
// colour codes and the box rasterizer state encoding.
package pong_pkg;

   localparam int unsigned X_W     = 9;
   localparam int unsigned Y_W     = 8;
   localparam int unsigned COLOR_W = 3;

   localparam logic [X_W-1:0] SCREEN_WIDTH_DEF  = 9'd320;
   localparam logic [X_W-1:0] SCREEN_HEIGHT_DEF = 9'd240;

   localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'd0;
   localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'd1;
   localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'd2;
   localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'd3;
   localparam logic [COLOR_W-1:0] COLOR_RED     = 3'd4;
   localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'd5;
   localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'd6;
   localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DRAW = 2'd1,
      S_DONE = 2'd2
   } box_state_t;

endpackage

// File: rtl/box_rasterizer_raster_counter.sv
// Row-major column/row walker over a w_eff x h_eff rectangle.
module raster_counter #(
   parameter int unsigned W = 9
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [W-1:0] i_w_eff,
   input  logic [W-1:0] i_h_eff,
   input  logic         i_load,
   input  logic         i_step,
   output logic [W-1:0] o_col,
   output logic [W-1:0] o_row,
   output logic         o_last
);

   logic [W-1:0] r_col;
   logic [W-1:0] r_row;
   logic         w_col_end;
   logic         w_row_end;

   assign w_col_end = (r_col == i_w_eff - W'(1));
   assign w_row_end = (r_row == i_h_eff - W'(1));

   // Clear on load; otherwise advance one pixel per step, wrapping col into row.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_load) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_step) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + W'(1);
         end else begin
            r_col <= r_col + W'(1);
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_col_end & w_row_end;

endmodule

// File: rtl/box_rasterizer.sv
// Accepts one rectangle command, clips it to the screen and streams its
// pixels row-major over a valid/ready pixel port.
module box_rasterizer
   import pong_pkg::*;
#(
   parameter logic [X_W-1:0] SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
   parameter logic [X_W-1:0] SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [X_W-1:0]     in_box_x,
   input  logic [X_W-1:0]     in_box_y,
   input  logic [X_W-1:0]     in_box_w,
   input  logic [X_W-1:0]     in_box_h,
   input  logic [COLOR_W-1:0] in_box_color,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [X_W-1:0]     out_x,
   output logic [Y_W-1:0]     out_y,
   output logic [COLOR_W-1:0] out_color,
   output logic               done,
   output logic               busy
);

   box_state_t         r_state;
   logic               r_s_ready;
   logic               r_m_valid;
   logic               r_done;
   logic               r_busy;
   logic [X_W-1:0]     r_x;
   logic [X_W-1:0]     r_y;
   logic [X_W-1:0]     r_w_eff;
   logic [X_W-1:0]     r_h_eff;
   logic [COLOR_W-1:0] r_color;

   logic [X_W:0]       w_rem_w;
   logic [X_W:0]       w_rem_h;
   logic [X_W-1:0]     w_w_clip;
   logic [X_W-1:0]     w_h_clip;
   logic               w_empty;
   logic               w_cmd_xfer;
   logic               w_pix_xfer;
   logic [X_W-1:0]     w_col;
   logic [X_W-1:0]     w_row;
   logic               w_last;

   // Space left to the screen edge, one bit wider so x+w never wraps.
   assign w_rem_w  = {1'b0, SCREEN_WIDTH}  - {1'b0, in_box_x};
   assign w_rem_h  = {1'b0, SCREEN_HEIGHT} - {1'b0, in_box_y};
   assign w_w_clip = ({1'b0, in_box_w} < w_rem_w) ? in_box_w : w_rem_w[X_W-1:0];
   assign w_h_clip = ({1'b0, in_box_h} < w_rem_h) ? in_box_h : w_rem_h[X_W-1:0];
   assign w_empty  = (in_box_x >= SCREEN_WIDTH) || (in_box_y >= SCREEN_HEIGHT) ||
                     (in_box_w == '0) || (in_box_h == '0);

   assign w_cmd_xfer = s_valid & r_s_ready;
   assign w_pix_xfer = r_m_valid & m_ready;

   raster_counter #(
      .W (X_W)
   ) u_raster_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .i_w_eff (r_w_eff),
      .i_h_eff (r_h_eff),
      .i_load  (w_cmd_xfer),
      .i_step  (w_pix_xfer),
      .o_col   (w_col),
      .o_row   (w_row),
      .o_last  (w_last)
   );

   // Command FSM: idle -> draw (skipped for empty boxes) -> one-cycle done.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_s_ready <= 1'b1;
         r_m_valid <= 1'b0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_w_eff   <= '0;
         r_h_eff   <= '0;
         r_color   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_valid) begin
                  r_x       <= in_box_x;
                  r_y       <= in_box_y;
                  r_w_eff   <= w_w_clip;
                  r_h_eff   <= w_h_clip;
                  r_color   <= in_box_color;
                  r_s_ready <= 1'b0;
                  r_busy    <= 1'b1;
                  if (w_empty) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_DRAW;
                     r_m_valid <= 1'b1;
                  end
               end
            end
            S_DRAW: begin
               if (m_ready && w_last) begin
                  r_state   <= S_DONE;
                  r_m_valid <= 1'b0;
                  r_done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state   <= S_IDLE;
               r_done    <= 1'b0;
               r_busy    <= 1'b0;
               r_s_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs are forced quiet for as long as reset is asserted, not just after its edge.
   assign s_ready   = r_s_ready & reset_n;
   assign m_valid   = r_m_valid & reset_n;
   assign done      = r_done & reset_n;
   assign busy      = r_busy & reset_n;
   assign out_x     = reset_n ? (r_x + w_col) : '0;
   assign out_y     = reset_n ? Y_W'(r_y + w_row) : '0;
   assign out_color = reset_n ? r_color : '0;

endmodule

// File: tb/tb_box_rasterizer.sv
// Bench for box_rasterizer on an 8x6 screen with a pixel-list reference model.
module tb_box_rasterizer;

   localparam int SW = 8;
   localparam int SH = 6;

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       m_ready = 1'b0;
   logic [8:0] in_box_x = '0;
   logic [8:0] in_box_y = '0;
   logic [8:0] in_box_w = '0;
   logic [8:0] in_box_h = '0;
   logic [2:0] in_box_color = '0;
   logic       s_ready;
   logic       m_valid;
   logic [8:0] out_x;
   logic [7:0] out_y;
   logic [2:0] out_color;
   logic       done;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   int exp_x[$];
   int exp_y[$];

   always #5 clock = ~clock;

   box_rasterizer #(
      .SCREEN_WIDTH  (9'd8),
      .SCREEN_HEIGHT (9'd6)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .in_box_x     (in_box_x),
      .in_box_y     (in_box_y),
      .in_box_w     (in_box_w),
      .in_box_h     (in_box_h),
      .in_box_color (in_box_color),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_color    (out_color),
      .done         (done),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference: every on-screen pixel of the requested box, row-major.
   task automatic build_model(input int x, input int y, input int w, input int h);
      exp_x.delete();
      exp_y.delete();
      for (int r = y; r < y + h && r < SH; r++)
         for (int c = x; c < x + w && c < SW; c++) begin
            exp_x.push_back(c);
            exp_y.push_back(r);
         end
   endtask

   // mode 0: m_ready always 1; 1: random; 2: pattern 1,0,0,1,1,0,1 then 1.
   task automatic run_cmd(input int x, input int y, input int w, input int h,
                          input logic [2:0] col, input int mode,
                          input logic hold_next, input int nx, input int ny,
                          input int nw, input int nh, input logic [2:0] ncol);
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int npix, got, cyc, pidx, ex, ey;
      logic saw_done, saw_valid, held;
      logic [8:0] hx;
      logic [7:0] hy;
      logic [2:0] hc;
      build_model(x, y, w, h);
      npix = exp_x.size();
      got = 0; cyc = 0; pidx = 0;
      saw_done = 0; saw_valid = 0; held = 0;
      hx = '0; hy = '0; hc = '0;
      chk("idle_s_ready", s_ready, 1);
      chk("idle_m_valid", m_valid, 0);
      s_valid      = 1'b1;
      in_box_x     = 9'(x);
      in_box_y     = 9'(y);
      in_box_w     = 9'(w);
      in_box_h     = 9'(h);
      in_box_color = col;
      m_ready      = 1'($urandom_range(0, 1));
      tick();
      if (hold_next) begin
         in_box_x     = 9'(nx);
         in_box_y     = 9'(ny);
         in_box_w     = 9'(nw);
         in_box_h     = 9'(nh);
         in_box_color = ncol;
      end else begin
         s_valid      = 1'b0;
         in_box_x     = 9'($urandom);
         in_box_y     = 9'($urandom);
         in_box_w     = 9'($urandom);
         in_box_h     = 9'($urandom);
         in_box_color = 3'($urandom);
      end
      chk("busy_after_accept", busy, 1);
      chk("s_ready_after_accept", s_ready, 0);
      while (!saw_done && cyc < 300) begin
         cyc++;
         if (done) begin
            saw_done = 1;
            chk("done_m_valid", m_valid, 0);
            chk("done_busy", busy, 1);
            if (mode == 0) chk("done_latency", cyc, npix + 1);
         end else begin
            chk("draw_s_ready", s_ready, 0);
            if (m_valid) begin
               saw_valid = 1;
               if (held) begin
                  chk("hold_x", out_x, hx);
                  chk("hold_y", out_y, hy);
                  chk("hold_color", out_color, hc);
               end
               case (mode)
                  0:       m_ready = 1'b1;
                  1:       m_ready = 1'($urandom_range(0, 1));
                  default: m_ready = (pidx < 7) ? 1'(pat[pidx]) : 1'b1;
               endcase
               pidx++;
               if (m_ready) begin
                  got++;
                  held = 0;
                  if (got > npix) begin
                     chk("pixel_overrun", got, npix);
                  end else begin
                     ex = exp_x.pop_front();
                     ey = exp_y.pop_front();
                     chk("pix_x", out_x, ex);
                     chk("pix_y", out_y, ey);
                     chk("pix_color", out_color, col);
                  end
               end else begin
                  held = 1;
                  hx = out_x; hy = out_y; hc = out_color;
               end
            end
            tick();
         end
      end
      chk("done_seen", saw_done, 1);
      chk("pixel_count", got, npix);
      if (npix == 0) chk("empty_no_valid", saw_valid, 0);
      tick();
      chk("done_one_cycle", done, 0);
      chk("s_ready_back", s_ready, 1);
      chk("busy_idle", busy, 0);
      m_ready = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_color", out_color, 0);
      reset_n = 1'b1;
      tick();

      // Basic fill, clipping, empties, backpressure
      run_cmd(2, 1, 3, 2, 3'd5, 0, 1'b0, 0, 0, 0, 0, 3'd0);
      run_cmd(6, 4, 5, 5, 3'd3, 0, 1'b0, 0, 0, 0, 0, 3'd0);
      run_cmd(8, 0, 3, 3, 3'd2, 0, 1'b0, 0, 0, 0, 0, 3'd0);
      run_cmd(0, 0, 0, 4, 3'd6, 0, 1'b0, 0, 0, 0, 0, 3'd0);
      run_cmd(0, 0, 2, 2, 3'd7, 2, 1'b0, 0, 0, 0, 0, 3'd0);

      // Reset mid-draw of a full-screen box
      s_valid = 1'b1;
      in_box_x = 9'd0; in_box_y = 9'd0; in_box_w = 9'd8; in_box_h = 9'd6;
      in_box_color = 3'd4;
      m_ready = 1'b1;
      tick();
      s_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("fs_m_valid", m_valid, 1);
         chk("fs_x", out_x, k);
         chk("fs_y", out_y, 0);
         tick();
      end
      reset_n = 1'b0;
      tick();
      chk("midrst_m_valid", m_valid, 0);
      chk("midrst_s_ready", s_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      reset_n = 1'b1;
      tick();
      chk("postrst_s_ready", s_ready, 1);
      chk("postrst_m_valid", m_valid, 0);
      run_cmd(1, 1, 1, 1, 3'd1, 0, 1'b0, 0, 0, 0, 0, 3'd0);

      // Back-to-back with s_valid held high
      run_cmd(1, 2, 2, 2, 3'd6, 0, 1'b1, 5, 3, 4, 2, 3'd2);
      run_cmd(5, 3, 4, 2, 3'd2, 1, 1'b0, 0, 0, 0, 0, 3'd0);

      // Randomized commands, including off-screen and zero-size ones
      for (int i = 0; i < 14; i++) begin
         run_cmd(int'($urandom_range(0, 9)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 9)), int'($urandom_range(0, 7)),
                 3'($urandom), int'($urandom_range(0, 2)),
                 1'b0, 0, 0, 0, 0, 3'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/box_rasterizer.md
Name: box_rasterizer

Overview:
- Consumer end of the box-command valid/ready interface driven by the screen drawer.
- Accepts one rectangle command (x, y, w, h, colour) and clips it to the screen.
- Emits the rectangle row-major, one pixel per handshake, on a pixel valid/ready port that feeds the VGA adapter. Tie m_ready high when the sink has no backpressure.

Parameters:
- SCREEN_WIDTH, 9'd320, visible columns; legal x is 0..SCREEN_WIDTH-1.
- SCREEN_HEIGHT, 9'd240, visible rows; legal y is 0..SCREEN_HEIGHT-1.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- s_valid  in  1  box command valid
- s_ready  out  1  block can accept a command
- in_box_x  in  9  left column
- in_box_y  in  9  top row
- in_box_w  in  9  width in pixels
- in_box_h  in  9  height in pixels
- in_box_color  in  3  fill colour
- m_valid  out  1  pixel valid (VGA plot)
- m_ready  in  1  pixel accepted
- out_x  out  9  pixel column
- out_y  out  8  pixel row
- out_color  out  3  pixel colour
- done  out  1  one-cycle pulse when a command finishes
- busy  out  1  high while not idle

Behaviour:
- Reset is synchronous on clock when reset_n=0.
  - State goes to S_IDLE; all counters and latched fields clear to 0.
  - While reset_n=0: s_ready=0, m_valid=0, done=0, busy=0; out_x, out_y, out_color read 0.
- Reset mid-draw aborts the command. No further pixels are emitted, and the next command starts fresh.
- Transfers:
  - A command transfers when s_valid & s_ready at a rising edge.
  - A pixel transfers when m_valid & m_ready at a rising edge.
- States:
  - S_IDLE: s_ready=1, m_valid=0. On a command transfer, latch x, y and colour, and compute the clipped extents using 10-bit arithmetic (no 9-bit overflow): w_eff = min(w, SCREEN_WIDTH-x), h_eff = min(h, SCREEN_HEIGHT-y).
    - If x>=SCREEN_WIDTH, y>=SCREEN_HEIGHT, w==0 or h==0, the command is empty: go to S_DONE.
    - Otherwise clear col and row to 0 and go to S_DRAW.
  - S_DRAW: m_valid=1, s_ready=0. Outputs are out_x = x+col, out_y = y+row, out_color = latched colour.
    - On each pixel transfer: if col==w_eff-1, set col=0 and row=row+1; otherwise col=col+1.
    - The transfer with col==w_eff-1 and row==h_eff-1 goes to S_DONE.
    - While m_ready=0, all outputs hold stable.
  - S_DONE: one cycle. done=1, m_valid=0, s_ready=0. Then go to S_IDLE.
- busy=1 in S_DRAW and S_DONE.
- Latency:
  - First pixel is valid the cycle after command acceptance.
  - With m_ready held high, a w_eff×h_eff box costs 1 + w_eff·h_eff + 1 cycles from acceptance until s_ready returns.
  - Back-to-back commands therefore have a 2-cycle gap beyond the pixel count.
- In S_IDLE, m_ready is ignored. Input fields are sampled only at command transfer, so changes at any other time have no effect.
- Output pixels are always on-screen: out_x < SCREEN_WIDTH and out_y < SCREEN_HEIGHT.
- A full-screen box emits exactly SCREEN_WIDTH·SCREEN_HEIGHT pixels (76800 at defaults).

Decomposition:
- Shared package pong_pkg holds:
  - SCREEN_WIDTH and SCREEN_HEIGHT defaults
  - coordinate widths (X_W=9, Y_W=8) and COLOR_W=3
  - the colour code constants
  - the state encoding typedef for this block
- One natural sub-module, raster_counter.
  - Inputs: w_eff, h_eff, load, step.
  - Outputs: col, row, last.
  - The FSM, clipping and handshakes stay in box_rasterizer.

Test Plan:
All scenarios use SCREEN_WIDTH=8, SCREEN_HEIGHT=6.
- Basic fill: cmd x=2,y=1,w=3,h=2,color=5, m_ready=1.
  - Pixels (2,1),(3,1),(4,1),(2,2),(3,2),(4,2), colour 5, on 6 consecutive cycles starting the cycle after acceptance.
  - done pulses the next cycle; s_ready=1 one cycle later.
- Clipping: cmd x=6,y=4,w=5,h=5.
  - Exactly 4 pixels: (6,4),(7,4),(6,5),(7,5), then done.
- Empty commands: x=8,w=3,h=3, then x=0,y=0,w=0,h=4.
  - Each yields zero pixels (m_valid never high) and a done pulse the cycle after acceptance.
- Backpressure: cmd x=0,y=0,w=2,h=2 with m_ready pattern 1,0,0,1,1,0,1.
  - out_x, out_y and out_color stay stable during the low cycles.
  - Exactly 4 transfers, in order (0,0),(1,0),(0,1),(1,1).
- Reset mid-draw: full-screen cmd; after 3 pixels drive reset_n=0 for one cycle.
  - m_valid=0 immediately after the reset edge; s_ready=1 the cycle after reset_n returns high.
  - A new cmd x=1,y=1,w=1,h=1 emits the single pixel (1,1).
- Back-to-back with s_valid held high: two cmds, the second presented only after the first is accepted.
  - The second is accepted exactly in the S_IDLE cycle following done.
  - No pixel is duplicated or lost.
